fetch_ctrl: RTL and testbench

- Fetch-stage sequencer between the PC/redirect sources and the instruction cache request/response interface.
- Owns the architectural fetch PC. Issues one cache request per cycle under a valid/ready handshake, tracking up to MAX_OUT outstanding requests.
- On any redirect, discards stale in-flight responses and emits in-order fetch packets to decode through a response FIFO.
- Raises an ADEF fetch packet for a misaligned PC and halts issue until the next flush.

---
 rtl/fetch_ctrl.sv | 237 +++++++++++++++++++++++
 tb/tb_fetch_ctrl.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_ctrl.sv
`timescale 1ns/1ps
// fetch_ctrl: fetch-stage sequencer between the PC/redirect sources and the
// instruction cache.
//
// Purpose:
//   Owns the fetch PC. Issues at most one cache request per cycle and tracks
//   up to MAX_OUT requests in flight plus buffered responses. Responses that
//   belong to requests issued before a redirect are discarded. Live responses
//   are queued in order and presented to decode. A misaligned PC produces a
//   single ADEF packet, after which issue halts until the next flush.
//
// Ports:
//   clk, rst (async, active-low)
//   flush/new_pc         backend redirect (highest priority)
//   bp_taken/bp_target   predictor redirect
//   pause, stall         hold request issue
//   iuncache             1: 4-byte uncached fetch, 0: 8-byte cached fetch
//   ic_req_*             cache request (valid/ready)
//   ic_resp_valid/data   cache response, in request order
//   fetch_*              packet to decode (valid/ready)
//   dbg_state_o          1 while halted after an address error
//
// Handshake rule:
//   A transfer happens on a rising clk edge when valid and ready are both 1.
//   A valid packet stays stable until it is accepted or a redirect clears it.
//   Once raised, ic_req_valid may still drop when pause/stall rises.
//
// Optional feature (macro FETCH_PERF_CNT_EN):
//   Adds perf_req_cnt, perf_kill_cnt and perf_hold_cnt. These are free-running
//   32-bit counters.
module fetch_ctrl #(
    parameter logic [31:0]       RESET_PC  = 32'h1c000000,
    parameter int                MAX_OUT   = 4,
    parameter int                EXCP_W    = 7,
    parameter logic [EXCP_W-1:0] ADEF_CODE = EXCP_W'(8'h08),
    parameter logic [EXCP_W-1:0] NOP_CODE  = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic [31:0]       new_pc,
    input  logic              bp_taken,
    input  logic [31:0]       bp_target,
    input  logic              pause,
    input  logic              stall,
    input  logic              iuncache,
    output logic              ic_req_valid,
    input  logic              ic_req_ready,
    output logic [31:0]       ic_req_addr,
    output logic              ic_req_uncached,
    input  logic              ic_resp_valid,
    input  logic [63:0]       ic_resp_data,
    output logic              fetch_valid,
    input  logic              fetch_ready,
    output logic [31:0]       fetch_pc,
    output logic [63:0]       fetch_inst,
    output logic              fetch_inst_en2,
    output logic              fetch_excp,
    output logic [EXCP_W-1:0] fetch_excp_cause,
`ifdef FETCH_PERF_CNT_EN
    output logic [31:0]       perf_req_cnt,
    output logic [31:0]       perf_kill_cnt,
    output logic [31:0]       perf_hold_cnt,
`endif
    output logic              dbg_state_o
);

    localparam int CW = $clog2(MAX_OUT + 1);
    localparam int PW = $clog2(MAX_OUT);
    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_OUT);

    typedef enum logic {S_RUN = 1'b0, S_HALT = 1'b1} state_e;

    typedef struct packed {
        logic [31:0]       pc;
        logic [63:0]       inst;
        logic              en2;
        logic              excp;
        logic [EXCP_W-1:0] cause;
    } pkt_t;

    state_e          state_q, state_d;
    logic [31:0]     pc_q, pc_d;
    logic [CW-1:0]   inflight_q, inflight_d;
    logic [CW-1:0]   kill_q, kill_d;
    logic [CW-1:0]   fifo_cnt_q, fifo_cnt_d;
    logic [PW-1:0]   tag_wr_q, tag_wr_d, tag_rd_q, tag_rd_d;
    logic [PW-1:0]   fifo_wr_q, fifo_wr_d, fifo_rd_q, fifo_rd_d;

    logic [31:0]     tag_pc_q  [MAX_OUT];
    logic            tag_unc_q [MAX_OUT];
    pkt_t            fifo_q    [MAX_OUT];

    logic run, aligned, room, hs, resp, redirect, pop;
    logic live_push, adef_push, push;
    pkt_t push_pkt, head;

    assign run      = (state_q == S_RUN);
    assign aligned  = (pc_q[1:0] == 2'b00);
    assign room     = ({1'b0, inflight_q} + {1'b0, fifo_cnt_q}) < {1'b0, MAX_CNT};
    // Gated by rst so every control output reads 0 while reset is held.
    assign ic_req_valid    = rst & run & ~pause & ~stall & aligned & room;
    assign ic_req_addr     = pc_q;
    assign ic_req_uncached = ic_req_valid & iuncache;
    assign hs       = ic_req_valid & ic_req_ready;
    // A response with nothing outstanding is a protocol error and is ignored.
    assign resp     = ic_resp_valid & (inflight_q != '0);
    // The predictor cannot pull the machine out of HALT; only flush can.
    assign redirect = flush | (run & bp_taken);
    assign fetch_valid = (fifo_cnt_q != '0);
    assign pop      = fetch_valid & fetch_ready;

    assign live_push = resp & (kill_q == '0) & ~redirect;
    // kill_q <= inflight_q always holds, so inflight_q==0 implies nothing
    // stale is still pending; both are checked to keep the intent explicit.
    assign adef_push = run & ~aligned & ~redirect & (inflight_q == '0) &
                       (kill_q == '0) & ((fifo_cnt_q != MAX_CNT) | pop);
    assign push = live_push | adef_push;

    always_comb begin
        push_pkt = '0;
        if (adef_push) begin
            push_pkt.pc    = pc_q;
            push_pkt.excp  = 1'b1;
            push_pkt.cause = ADEF_CODE;
        end else begin
            push_pkt.pc    = tag_pc_q[tag_rd_q];
            push_pkt.inst  = ic_resp_data;
            push_pkt.en2   = ~tag_unc_q[tag_rd_q];
            push_pkt.cause = NOP_CODE;
        end
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        inflight_d = inflight_q + CW'(hs) - CW'(resp);
        kill_d     = kill_q;
        fifo_cnt_d = fifo_cnt_q + CW'(push) - CW'(pop);
        tag_wr_d   = hs   ? tag_wr_q + PW'(1)  : tag_wr_q;
        tag_rd_d   = resp ? tag_rd_q + PW'(1)  : tag_rd_q;
        fifo_wr_d  = push ? fifo_wr_q + PW'(1) : fifo_wr_q;
        fifo_rd_d  = pop  ? fifo_rd_q + PW'(1) : fifo_rd_q;

        if (resp && kill_q != '0) begin
            kill_d = kill_q - CW'(1);
        end
        if (hs) begin
            pc_d = pc_q + (iuncache ? 32'd4 : 32'd8);
        end
        if (adef_push) begin
            state_d = S_HALT;
        end

        if (flush) begin
            pc_d    = new_pc;
            state_d = S_RUN;
        end else if (run && bp_taken) begin
            pc_d = bp_target;
        end

        // Everything still outstanding after a redirect is stale, including
        // a request accepted this very cycle. Counting from inflight_d keeps
        // back-to-back redirects from counting the same request twice.
        if (redirect) begin
            kill_d     = inflight_d;
            fifo_cnt_d = '0;
            fifo_wr_d  = '0;
            fifo_rd_d  = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_RUN;
            pc_q       <= RESET_PC;
            inflight_q <= '0;
            kill_q     <= '0;
            fifo_cnt_q <= '0;
            tag_wr_q   <= '0;
            tag_rd_q   <= '0;
            fifo_wr_q  <= '0;
            fifo_rd_q  <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            inflight_q <= inflight_d;
            kill_q     <= kill_d;
            fifo_cnt_q <= fifo_cnt_d;
            tag_wr_q   <= tag_wr_d;
            tag_rd_q   <= tag_rd_d;
            fifo_wr_q  <= fifo_wr_d;
            fifo_rd_q  <= fifo_rd_d;
        end
    end

    // Storage arrays carry no reset; occupancy counters qualify their contents.
    always_ff @(posedge clk) begin
        if (hs) begin
            tag_pc_q[tag_wr_q]  <= pc_q;
            tag_unc_q[tag_wr_q] <= iuncache;
        end
        if (push) begin
            fifo_q[fifo_wr_q] <= push_pkt;
        end
    end

    assign head             = fifo_q[fifo_rd_q];
    assign fetch_pc         = fetch_valid ? head.pc    : '0;
    assign fetch_inst       = fetch_valid ? head.inst  : '0;
    assign fetch_inst_en2   = fetch_valid & head.en2;
    assign fetch_excp       = fetch_valid & head.excp;
    assign fetch_excp_cause = fetch_valid ? head.cause : '0;
    assign dbg_state_o      = (state_q == S_HALT);

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_req_q, perf_kill_q, perf_hold_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_req_q  <= '0;
            perf_kill_q <= '0;
            perf_hold_q <= '0;
        end else begin
            if (hs) perf_req_q <= perf_req_q + 32'd1;
            // A response landing on a redirect cycle is dropped as well.
            if (resp && (kill_q != '0 || redirect)) perf_kill_q <= perf_kill_q + 32'd1;
            if (run && !ic_req_valid) perf_hold_q <= perf_hold_q + 32'd1;
        end
    end

    assign perf_req_cnt  = perf_req_q;
    assign perf_kill_cnt = perf_kill_q;
    assign perf_hold_cnt = perf_hold_q;
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
`timescale 1ns/1ps
module tb_fetch_ctrl;

    typedef struct packed {
        logic [31:0] pc;
        logic [63:0] inst;
        logic        en2;
        logic        excp;
        logic [6:0]  cause;
    } pkt_t;

    typedef struct packed {
        logic [31:0] pc;
        logic        unc;
        logic        stale;
    } req_t;

    typedef struct packed {
        logic [31:0] addr;
        int          due;
    } cache_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush, bp_taken, pause, stall, iuncache;
    logic [31:0] new_pc, bp_target;
    logic        ic_req_valid, ic_req_ready, ic_req_uncached;
    logic [31:0] ic_req_addr;
    logic        ic_resp_valid;
    logic [63:0] ic_resp_data;
    logic        fetch_valid, fetch_ready;
    logic [31:0] fetch_pc;
    logic [63:0] fetch_inst;
    logic        fetch_inst_en2, fetch_excp;
    logic [6:0]  fetch_excp_cause;
    logic        dbg_state_o;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_req_cnt, perf_kill_cnt, perf_hold_cnt;
`endif

    fetch_ctrl dut (
        .clk(clk), .rst(rst),
        .flush(flush), .new_pc(new_pc),
        .bp_taken(bp_taken), .bp_target(bp_target),
        .pause(pause), .stall(stall), .iuncache(iuncache),
        .ic_req_valid(ic_req_valid), .ic_req_ready(ic_req_ready),
        .ic_req_addr(ic_req_addr), .ic_req_uncached(ic_req_uncached),
        .ic_resp_valid(ic_resp_valid), .ic_resp_data(ic_resp_data),
        .fetch_valid(fetch_valid), .fetch_ready(fetch_ready),
        .fetch_pc(fetch_pc), .fetch_inst(fetch_inst),
        .fetch_inst_en2(fetch_inst_en2), .fetch_excp(fetch_excp),
        .fetch_excp_cause(fetch_excp_cause),
`ifdef FETCH_PERF_CNT_EN
        .perf_req_cnt(perf_req_cnt), .perf_kill_cnt(perf_kill_cnt),
        .perf_hold_cnt(perf_hold_cnt),
`endif
        .dbg_state_o(dbg_state_o)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- scoreboard state ----------------
    int errors = 0;
    int checks = 0;

    logic [31:0] m_pc;
    logic        m_halt;
    req_t        m_out[$];   // requests the cache still owes, oldest first
    pkt_t        m_pkt[$];   // packets decode has yet to accept
    cache_t      cache_q[$];
    logic        cache_hold = 1'b0;

    logic [31:0] req_log[$];
    pkt_t        pop_log[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] mkdata(input logic [31:0] a);
        return {a ^ 32'h5a5a5a5a, a};
    endfunction

    function automatic logic [31:0] rl(input int i);
        if (i < req_log.size()) return req_log[i];
        return 32'hffffffff;
    endfunction

    function automatic pkt_t pl(input int i);
        pkt_t p;
        p = '1;
        if (i < pop_log.size()) p = pop_log[i];
        return p;
    endfunction

    function automatic int cnt_addr(input logic [31:0] a);
        int n = 0;
        foreach (req_log[i]) if (req_log[i] == a) n++;
        return n;
    endfunction

    // ---------------- cache responder ----------------
    always @(posedge clk) begin
        #1;
        if (!cache_hold && cache_q.size() != 0 && cache_q[0].due <= cyc) begin
            ic_resp_valid = 1'b1;
            ic_resp_data  = mkdata(cache_q[0].addr);
            void'(cache_q.pop_front());
        end else begin
            ic_resp_valid = 1'b0;
            ic_resp_data  = '0;
        end
    end

    // ---------------- compare + model ----------------
    always @(negedge clk) begin
        logic exp_v, hs, resp, redir;
        req_t r;
        pkt_t p;
        if (!rst) begin
            m_pc   = 32'h1c000000;
            m_halt = 1'b0;
            m_out.delete();
            m_pkt.delete();
            cache_q.delete();
        end else begin
            exp_v = !m_halt && !pause && !stall && (m_pc[1:0] == 2'b00) &&
                    ((m_out.size() + m_pkt.size()) < 4);
            chk("req_valid", 64'(ic_req_valid), 64'(exp_v));
            chk("req_addr", 64'(ic_req_addr), 64'(m_pc));
            if (exp_v) chk("req_uncached", 64'(ic_req_uncached), 64'(iuncache));
            chk("fetch_valid", 64'(fetch_valid), 64'(m_pkt.size() != 0));
            if (m_pkt.size() != 0) begin
                chk("fetch_pc", 64'(fetch_pc), 64'(m_pkt[0].pc));
                chk("fetch_inst", fetch_inst, m_pkt[0].inst);
                chk("fetch_en2", 64'(fetch_inst_en2), 64'(m_pkt[0].en2));
                chk("fetch_excp", 64'(fetch_excp), 64'(m_pkt[0].excp));
                chk("fetch_cause", 64'(fetch_excp_cause), 64'(m_pkt[0].cause));
            end
            chk("halt_state", 64'(dbg_state_o), 64'(m_halt));

            if (ic_req_valid && ic_req_ready) begin
                req_log.push_back(ic_req_addr);
                cache_q.push_back('{addr: ic_req_addr, due: cyc + 1});
            end
            if (fetch_valid && fetch_ready)
                pop_log.push_back('{fetch_pc, fetch_inst, fetch_inst_en2, fetch_excp, fetch_excp_cause});

            // Advance the model across the coming edge.
            hs    = exp_v && ic_req_ready;
            resp  = ic_resp_valid && (m_out.size() != 0);
            redir = flush || (!m_halt && bp_taken);
            if (m_pkt.size() != 0 && fetch_ready) void'(m_pkt.pop_front());
            if (resp) begin
                r = m_out.pop_front();
                if (!r.stale && !redir) begin
                    p = '{r.pc, mkdata(r.pc), !r.unc, 1'b0, 7'h00};
                    m_pkt.push_back(p);
                end
            end
            if (hs) begin
                m_out.push_back('{m_pc, iuncache, 1'b0});
                if (!redir) m_pc = m_pc + (iuncache ? 32'd4 : 32'd8);
            end
            if (!m_halt && m_pc[1:0] != 2'b00 && !redir && m_out.size() == 0 && m_pkt.size() < 4) begin
                p = '{m_pc, 64'd0, 1'b0, 1'b1, 7'h08};
                m_pkt.push_back(p);
                m_halt = 1'b1;
            end
            if (redir) begin
                foreach (m_out[i]) m_out[i].stale = 1'b1;
                m_pkt.delete();
                if (flush) begin
                    m_pc   = new_pc;
                    m_halt = 1'b0;
                end else begin
                    m_pc = bp_target;
                end
            end
        end
    end

    // ---------------- driver ----------------
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic clear_logs();
        req_log.delete();
        pop_log.delete();
    endtask

    task automatic do_flush(input logic [31:0] pc);
        flush  = 1'b1;
        new_pc = pc;
        step(1);
        flush  = 1'b0;
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1);
    end

    initial begin
        rst = 1'b0;
        flush = 0; bp_taken = 0; pause = 0; stall = 0; iuncache = 0;
        new_pc = '0; bp_target = '0;
        ic_req_ready = 1'b1; fetch_ready = 1'b1;
        ic_resp_valid = 1'b0; ic_resp_data = '0;
        step(3);

        // Reset values
        chk("rst_req_valid", 64'(ic_req_valid), 64'd0);
        chk("rst_req_addr", 64'(ic_req_addr), 64'h1c000000);
        chk("rst_req_unc", 64'(ic_req_uncached), 64'd0);
        chk("rst_fetch_valid", 64'(fetch_valid), 64'd0);
        chk("rst_fetch_pc", 64'(fetch_pc), 64'd0);
        chk("rst_fetch_inst", fetch_inst, 64'd0);
        chk("rst_fetch_excp", 64'({fetch_inst_en2, fetch_excp, fetch_excp_cause}), 64'd0);
        chk("rst_state", 64'(dbg_state_o), 64'd0);

        // Cached sequential fetch
        rst = 1'b1;
        clear_logs();
        step(10);
        chk("t1_req0", 64'(rl(0)), 64'h1c000000);
        chk("t1_req1", 64'(rl(1)), 64'h1c000008);
        chk("t1_req2", 64'(rl(2)), 64'h1c000010);
        chk("t1_pkt0_pc", 64'(pl(0).pc), 64'h1c000000);
        chk("t1_pkt0_inst", pl(0).inst, 64'h465a5a5a_1c000000);
        chk("t1_pkt0_en2", 64'(pl(0).en2), 64'd1);
        chk("t1_pkt1_pc", 64'(pl(1).pc), 64'h1c000008);
        stall = 1'b1; step(2); stall = 1'b0;
        pause = 1'b1; step(2); pause = 1'b0;
        step(3);

        // Uncached fetch
        iuncache = 1'b1;
        do_flush(32'h1c000100);
        clear_logs();
        step(8);
        chk("t2_req0", 64'(rl(0)), 64'h1c000100);
        chk("t2_req1", 64'(rl(1)), 64'h1c000104);
        chk("t2_req2", 64'(rl(2)), 64'h1c000108);
        chk("t2_pkt0_pc", 64'(pl(0).pc), 64'h1c000100);
        chk("t2_pkt0_en2", 64'(pl(0).en2), 64'd0);
        iuncache = 1'b0;

        // Flush with three requests outstanding
        pause = 1'b1; step(4);
        cache_hold = 1'b1;
        do_flush(32'h1c000200);
        pause = 1'b0;
        clear_logs();
        step(3);
        chk("t3_issued", 64'(req_log.size()), 64'd3);
        ic_req_ready = 1'b0;
        do_flush(32'h1c001000);
        ic_req_ready = 1'b1;
        cache_hold = 1'b0;
        clear_logs();
        step(12);
        chk("t3_req0", 64'(rl(0)), 64'h1c001000);
        chk("t3_pkt0_pc", 64'(pl(0).pc), 64'h1c001000);
        chk("t3_pkt0_inst", pl(0).inst, 64'h465a4a5a_1c001000);

        // Flush and bp_taken together
        flush = 1'b1; new_pc = 32'h1c003000;
        bp_taken = 1'b1; bp_target = 32'h1c002000;
        step(1);
        flush = 1'b0; bp_taken = 1'b0;
        clear_logs();
        step(8);
        chk("t4_req0", 64'(rl(0)), 64'h1c003000);
        chk("t4_no_bp_target", 64'(cnt_addr(32'h1c002000)), 64'd0);
        bp_taken = 1'b1; bp_target = 32'h1c004000;
        step(1);
        bp_taken = 1'b0;
        clear_logs();
        step(6);
        chk("t4_bp_req0", 64'(rl(0)), 64'h1c004000);

        // Decode back-pressure fills the window
        pause = 1'b1; step(4);
        fetch_ready = 1'b0;
        do_flush(32'h1c005000);
        pause = 1'b0;
        clear_logs();
        step(10);
        chk("t5_issued", 64'(req_log.size()), 64'd4);
        chk("t5_req_valid", 64'(ic_req_valid), 64'd0);
        chk("t5_head_pc", 64'(fetch_pc), 64'h1c005000);
        fetch_ready = 1'b1;
        step(1);
        fetch_ready = 1'b0;
        step(4);
        chk("t5_issued_after_pop", 64'(req_log.size()), 64'd5);
        chk("t5_req4", 64'(rl(4)), 64'h1c005020);
        chk("t5_pop0", 64'(pl(0).pc), 64'h1c005000);
        fetch_ready = 1'b1;
        step(6);

        // Misaligned PC -> ADEF, then resume
        pause = 1'b1; step(3);
        fetch_ready = 1'b0;
        do_flush(32'h1c000002);
        pause = 1'b0;
        clear_logs();
        step(6);
        chk("t6_no_req", 64'(req_log.size()), 64'd0);
        chk("t6_valid", 64'(fetch_valid), 64'd1);
        chk("t6_pc", 64'(fetch_pc), 64'h1c000002);
        chk("t6_excp", 64'(fetch_excp), 64'd1);
        chk("t6_cause", 64'(fetch_excp_cause), 64'h08);
        chk("t6_en2", 64'(fetch_inst_en2), 64'd0);
        chk("t6_inst", fetch_inst, 64'd0);
        chk("t6_halt", 64'(dbg_state_o), 64'd1);
        fetch_ready = 1'b1;
        do_flush(32'h1c000000);
        clear_logs();
        step(6);
        chk("t6_resume_req0", 64'(rl(0)), 64'h1c000000);
        chk("t6_resume_state", 64'(dbg_state_o), 64'd0);
        chk("t6_resume_pkt0", 64'(pl(0).pc), 64'h1c000000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
